piezo_drv: RTL and testbench
============================

// Module: piezo_drv
// PURPOSE
//  Output stage after the tune player: takes its raw square-wave tone and drives the piezo
//  pins as a complementary pair. Adds dead-time on each tone edge and volume control by
//  PWM gating. A DC-hold watchdog cuts drive if the tone stalls.
//  Output pins always in one of three states: both low, piezo high only, piezo_n high only.
// PARAMETERS
//  DEAD_CYC  8      clocks both outputs held low after every tone edge (>=1)
//  VOL_W     4      width of vol input and of PWM carrier counter
//  HOLD_MAX  65535  max clocks tone_in may stay constant before trip (> longest half-period, 14205)
// PORTS
//  clk      in   1      system clock
//  rst_n    in   1      asynchronous active-low reset
//  en       in   1      drive enable; low forces both outputs low
//  tone_in  in   1      raw tone from player, same clock domain, level signal
//  vol      in   VOL_W  duty: 0=mute, all-ones=full (no gating), else vol/2^VOL_W
//  piezo    out  1      positive drive, registered
//  piezo_n  out  1      negative drive, registered
//  fault    out  1      sticky DC-hold trip flag; cleared by en low or reset
// BEHAVIOUR
//  Reset: state=OFF, piezo=0, piezo_n=0, fault=0, dead/hold/pwm counters=0, tone_d=0.
//  tone_d <= tone_in every clock. edge = tone_in ^ tone_d. Target side tgt = tone_in.
//  FSM states: OFF, DEAD, DRV_P, DRV_N, TRIP.
//   OFF : en=1 & edge -> DEAD (dead_cnt cleared). Else stay. No drive.
//   DEAD: dead_cnt++. edge -> restart DEAD, dead_cnt=0, tgt follows tone_in.
//         dead_cnt==DEAD_CYC-1 -> DRV_P if tone_in=1 else DRV_N.
//   DRV_P/DRV_N: edge -> DEAD. hold_cnt++ each clock. hold_cnt==HOLD_MAX-1 -> TRIP.
//   TRIP: no drive. fault set. edge -> DEAD (fault stays set).
//   en=0 in any state -> OFF next clock. Same clock: both outputs forced low, fault cleared.
//     This overrides edge and trip. en re-asserted: wait in OFF for the next edge.
//  hold_cnt is cleared on every edge and in OFF. It saturates and does not wrap.
//  Outputs are registered from next-state:
//   piezo   <= (nxt==DRV_P) & gate
//   piezo_n <= (nxt==DRV_N) & gate
//  gate: vol==0 -> 0. vol=={VOL_W{1}} -> 1. Else pwm_cnt < vol.
//  pwm_cnt is a free-running VOL_W-bit wrap counter, never reset by FSM events.
//  Latency: tone_in sampled new at edge k.
//   Old side low at k+1.
//   New side high at k+1+DEAD_CYC, subject to gate.
//  Invariant: piezo & piezo_n is never 1 on any cycle. Bench asserts this every clock.
//  Reset mid-drive: both outputs drop asynchronously with rst_n.
// STRUCTURE
//  piezo_pkg: typedef enum logic [2:0] drv_state_t {OFF,DEAD,DRV_P,DRV_N,TRIP};
//             localparam default DEAD_CYC.
//  Sub-module vol_pwm (clk, rst_n, vol -> gate): holds pwm_cnt and the gate compare.
//  Top holds edge detect, dead/hold counters, FSM, fault flag, output flops.
// TESTING
//  1 en=1, vol=15, tone_in 0->1 sampled at edge k, DEAD_CYC=8
//     -> piezo=0 through k+8; piezo=1 at k+9; piezo_n=0 throughout.
//  2 Square tone, half-period 10643 clks, vol=15, 3 periods
//     -> each side high 10635 clks, 8-clk gaps low, never both high.
//  3 vol=4, tone held high
//     -> piezo high 4 of every 16 clks, aligned to pwm_cnt 0..3.
//     vol=0 -> piezo never high.
//  4 tone_in held high 65535 clks -> TRIP, piezo=0, fault=1.
//     Later tone edge -> drive resumes after DEAD_CYC, fault still 1.
//  5 Tone edges 3 clks apart during DEAD -> dead restarts each time.
//     Drive only after 8 quiet clks, on the side matching final tone_in.
//  6 en drops mid-DRV_N -> piezo_n=0 next clk, fault=0.
//     rst_n pulse mid-drive -> outputs 0 immediately, state OFF.

Source files
------------

// File: rtl/piezo_drv_pkg.sv
// Shared types and default parameters for the piezo output stage.
//   drv_state_t : FSM encoding used by piezo_drv
//   *_DEF       : default parameter values for the top and its interface
package piezo_drv_pkg;

    typedef enum logic [2:0] {
        OFF   = 3'd0,
        DEAD  = 3'd1,
        DRV_P = 3'd2,
        DRV_N = 3'd3,
        TRIP  = 3'd4
    } drv_state_t;

    localparam int DEAD_CYC_DEF = 8;
    localparam int VOL_W_DEF    = 4;
    localparam int HOLD_MAX_DEF = 65535;

endpackage

// File: rtl/piezo_drv_if.sv
// Control/status bundle between the tune player side and the piezo output stage.
//   en      : drive enable
//   tone_in : raw square-wave tone (level)
//   vol     : PWM volume, 0 = mute, all-ones = full
//   piezo   : positive drive pin
//   piezo_n : negative drive pin
//   fault   : sticky DC-hold trip flag
// master drives en/tone_in/vol; slave (the driver) returns pins and fault.
interface piezo_drv_if #(
    parameter int VOL_W = piezo_drv_pkg::VOL_W_DEF
) ();
    logic             en;
    logic             tone_in;
    logic [VOL_W-1:0] vol;
    logic             piezo;
    logic             piezo_n;
    logic             fault;

    modport master (output en, output tone_in, output vol,
                    input  piezo, input piezo_n, input fault);
    modport slave  (input  en, input tone_in, input vol,
                    output piezo, output piezo_n, output fault);
endinterface

// File: rtl/piezo_drv_vol_pwm.sv
// Volume gate: free-running PWM carrier compared against vol.
//   clk, rst_n : clock, async active-low reset
//   vol        : duty setting, 0 = never, all-ones = always, else vol/2^VOL_W
//   gate       : combinational enable for the output flops
module vol_pwm #(
    parameter int VOL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [VOL_W-1:0] vol,
    output logic             gate
);
    logic [VOL_W-1:0] pwm_cnt;

    // Carrier wraps freely; tone edges never re-phase it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= '0;
        else        pwm_cnt <= pwm_cnt + 1'b1;
    end

    // All-ones is special-cased so full volume has no one-clock notch per period.
    always_comb begin
        gate = 1'b0;
        if (vol == '0)    gate = 1'b0;
        else if (&vol)    gate = 1'b1;
        else              gate = (pwm_cnt < vol);
    end
endmodule

// File: rtl/piezo_drv.sv
// Piezo output stage: complementary drive with dead-time, PWM volume and a
// DC-hold watchdog.
//   clk, rst_n : clock, async active-low reset
//   bus        : piezo_drv_if.slave (en, tone_in, vol in; piezo, piezo_n, fault out)
// Pins are registered from next-state so they are never both high.
module piezo_drv
    import piezo_drv_pkg::*;
#(
    parameter int DEAD_CYC = DEAD_CYC_DEF,
    parameter int VOL_W    = VOL_W_DEF,
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    piezo_drv_if.slave  bus
);
    localparam int DW = $clog2(DEAD_CYC) + 1;
    localparam int HW = $clog2(HOLD_MAX + 1);

    drv_state_t    state, nxt;
    logic          tone_d;
    logic          tone_edge;
    logic [DW-1:0] dead_cnt;
    logic [HW-1:0] hold_cnt;
    logic          dead_done, hold_done;
    logic          gate;
    logic          piezo_q, piezo_n_q, fault_q;

    vol_pwm #(.VOL_W(VOL_W)) u_pwm (
        .clk   (clk),
        .rst_n (rst_n),
        .vol   (bus.vol),
        .gate  (gate)
    );

    assign tone_edge = bus.tone_in ^ tone_d;
    assign dead_done = (dead_cnt == DW'(DEAD_CYC - 1));
    assign hold_done = (hold_cnt == HW'(HOLD_MAX - 1));

    always_comb begin
        nxt = state;
        if (!bus.en) begin
            nxt = OFF;
        end else begin
            unique case (state)
                OFF:          if (tone_edge) nxt = DEAD;
                DEAD: begin
                    if (tone_edge)      nxt = DEAD;
                    else if (dead_done) nxt = bus.tone_in ? DRV_P : DRV_N;
                end
                DRV_P, DRV_N: begin
                    if (tone_edge)      nxt = DEAD;
                    else if (hold_done) nxt = TRIP;
                end
                TRIP:         if (tone_edge) nxt = DEAD;
                default:      nxt = OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= OFF;
            tone_d <= 1'b0;
        end else begin
            state  <= nxt;
            tone_d <= bus.tone_in;
        end
    end

    // Dead-time counter restarts on entry to DEAD and on every edge inside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dead_cnt <= '0;
        else if (nxt == DEAD && (state != DEAD || tone_edge))
            dead_cnt <= '0;
        else if (state == DEAD)
            dead_cnt <= dead_cnt + 1'b1;
    end

    // DC-hold watchdog: counts drive clocks since the last edge, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hold_cnt <= '0;
        else if (!bus.en || tone_edge || state == OFF)
            hold_cnt <= '0;
        else if ((state == DRV_P || state == DRV_N) && !hold_done)
            hold_cnt <= hold_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            piezo_q   <= 1'b0;
            piezo_n_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            piezo_q   <= (nxt == DRV_P) & gate;
            piezo_n_q <= (nxt == DRV_N) & gate;
            if (!bus.en)          fault_q <= 1'b0;
            else if (nxt == TRIP) fault_q <= 1'b1;
        end
    end

    assign bus.piezo   = piezo_q;
    assign bus.piezo_n = piezo_n_q;
    assign bus.fault   = fault_q;
endmodule

// File: tb/tb_piezo_drv.sv
// Directed bench for piezo_drv: a vector table for single-step behaviour plus
// hand-written sequences for PWM, dead-time restarts, square tone, trip and reset.
module tb_piezo_drv;
    localparam int DEAD = 8;
    localparam int HOLD = 2000;
    localparam int HALF = 1500;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    piezo_drv_if #(.VOL_W(4)) bus ();

    piezo_drv #(.DEAD_CYC(DEAD), .VOL_W(4), .HOLD_MAX(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int inv_bad = 0;

    typedef struct {
        logic       en;
        logic       tone;
        logic [3:0] vol;
        int         n;
        logic       p;
        logic       pn;
        logic       f;
        string      name;
    } vec_t;

    vec_t vecs [12];

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.piezo === 1'b1 && bus.piezo_n === 1'b1) begin
            inv_bad++;
            $display("FAIL invariant: piezo and piezo_n both high at %0t", $time);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_pins(input string nm, input logic p, input logic pn, input logic f);
        check({nm, ".piezo"},   32'(bus.piezo),   32'(p));
        check({nm, ".piezo_n"}, 32'(bus.piezo_n), 32'(pn));
        check({nm, ".fault"},   32'(bus.fault),   32'(f));
    endtask

    initial begin
        int hi, rises, bad, cp, cn;
        logic [63:0] trace;
        logic tone_now;

        vecs[0]  = '{1'b1, 1'b0, 4'd15, 3,  1'b0, 1'b0, 1'b0, "idle_no_edge"};
        vecs[1]  = '{1'b1, 1'b1, 4'd15, 1,  1'b0, 1'b0, 1'b0, "dead_k1"};
        vecs[2]  = '{1'b1, 1'b1, 4'd15, 7,  1'b0, 1'b0, 1'b0, "dead_k8"};
        vecs[3]  = '{1'b1, 1'b1, 4'd15, 1,  1'b1, 1'b0, 1'b0, "drv_p_k9"};
        vecs[4]  = '{1'b1, 1'b0, 4'd15, 1,  1'b0, 1'b0, 1'b0, "old_low_k1"};
        vecs[5]  = '{1'b1, 1'b0, 4'd15, 8,  1'b0, 1'b1, 1'b0, "drv_n_k9"};
        vecs[6]  = '{1'b0, 1'b0, 4'd15, 1,  1'b0, 1'b0, 1'b0, "en_drop"};
        vecs[7]  = '{1'b1, 1'b0, 4'd15, 12, 1'b0, 1'b0, 1'b0, "wait_off"};
        vecs[8]  = '{1'b1, 1'b1, 4'd15, 9,  1'b1, 1'b0, 1'b0, "resume_p"};
        vecs[9]  = '{1'b1, 1'b1, 4'd0,  2,  1'b0, 1'b0, 1'b0, "mute"};
        vecs[10] = '{1'b1, 1'b1, 4'd15, 1,  1'b1, 1'b0, 1'b0, "unmute"};
        vecs[11] = '{1'b0, 1'b0, 4'd15, 1,  1'b0, 1'b0, 1'b0, "en_over_edge"};

        // reset
        rst_n = 1'b0;
        bus.en = 1'b0; bus.tone_in = 1'b0; bus.vol = 4'd0;
        step(2);
        check_pins("reset", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // table
        foreach (vecs[i]) begin
            bus.en = vecs[i].en; bus.tone_in = vecs[i].tone; bus.vol = vecs[i].vol;
            step(vecs[i].n);
            check_pins(vecs[i].name, vecs[i].p, vecs[i].pn, vecs[i].f);
        end

        // PWM at vol=4 with tone held high
        bus.en = 1'b1; bus.tone_in = 1'b1; bus.vol = 4'd4;
        step(DEAD + 2);
        for (int t = 0; t < 64; t++) begin
            trace[t] = bus.piezo;
            step(1);
        end
        hi = 0; rises = 0;
        for (int t = 0; t < 64; t++) begin
            if (trace[t]) hi++;
            if (trace[t] && !trace[(t + 63) % 64]) rises++;
        end
        check("pwm4_high_count", 32'(hi), 32'd16);
        check("pwm4_bursts", 32'(rises), 32'd4);
        bus.vol = 4'd0;
        step(1);
        hi = 0;
        for (int t = 0; t < 32; t++) begin
            if (bus.piezo) hi++;
            step(1);
        end
        check("vol0_silent", 32'(hi), 32'd0);
        bus.vol = 4'd15;
        step(1);
        check("vol15_full", 32'(bus.piezo), 32'd1);

        // edges 3 clocks apart keep restarting dead time
        bad = 0;
        for (int e = 0; e < 4; e++) begin
            bus.tone_in = ~bus.tone_in;
            for (int t = 0; t < ((e == 3) ? DEAD : 3); t++) begin
                step(1);
                if (bus.piezo || bus.piezo_n) bad++;
            end
        end
        check("dead_restart_quiet", 32'(bad), 32'd0);
        step(1);
        check_pins("dead_restart_drive", 1'b1, 1'b0, 1'b0);

        // square tone, 3 periods
        tone_now = 1'b1;
        for (int h = 0; h < 6; h++) begin
            tone_now = ~tone_now;
            bus.tone_in = tone_now;
            cp = 0; cn = 0;
            for (int t = 0; t < HALF; t++) begin
                step(1);
                if (bus.piezo)   cp++;
                if (bus.piezo_n) cn++;
            end
            check($sformatf("sq_h%0d_p", h),  32'(cp), tone_now ? 32'(HALF - DEAD) : 32'd0);
            check($sformatf("sq_h%0d_pn", h), 32'(cn), tone_now ? 32'd0 : 32'(HALF - DEAD));
        end
        check("sq_no_fault", 32'(bus.fault), 32'd0);

        // DC-hold trip and recovery
        bus.tone_in = 1'b0;
        step(20);
        bus.tone_in = 1'b1;
        step(HOLD);
        check_pins("hold_pre_trip", 1'b1, 1'b0, 1'b0);
        step(DEAD + 2);
        check_pins("hold_trip", 1'b0, 1'b0, 1'b1);
        bus.tone_in = 1'b0;
        step(1);
        check_pins("trip_edge_dead", 1'b0, 1'b0, 1'b1);
        step(DEAD);
        check_pins("trip_resume_n", 1'b0, 1'b1, 1'b1);

        // enable drop mid DRV_N
        bus.en = 1'b0;
        step(1);
        check_pins("en_drop_drv_n", 1'b0, 1'b0, 1'b0);

        // async reset mid drive
        bus.en = 1'b1; bus.tone_in = 1'b1;
        step(DEAD + 1);
        check_pins("pre_reset_drive", 1'b1, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check_pins("async_reset", 1'b0, 1'b0, 1'b0);
        bus.en = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
        bus.en = 1'b1;
        step(12);
        check_pins("off_after_reset", 1'b0, 1'b0, 1'b0);

        check("invariant_never_both", 32'(inv_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
